// File: rtl/controle_atuadores_multi.sv
// N-channel timed/external-end actuator controller with a shared power interlock.
// Channels in EXCL_MASK run one at a time; extra requests queue and are granted lowest index first.
module controle_atuadores_multi #(
  parameter int              N_CH          = 3,
  parameter int              CNT_W         = 16,
  parameter int              TICK_DIV      = 50000,
  parameter int              TIMEOUT_TICKS = 30000,
  parameter logic [N_CH-1:0] EXCL_MASK     = 3'b011
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       liga,
  input  logic [N_CH-1:0]       aborta,
  input  logic [N_CH-1:0]       modo_ext,
  input  logic [N_CH*CNT_W-1:0] duracao,
  input  logic [N_CH-1:0]       fim_ext,
  output logic [N_CH-1:0]       saida,
  output logic [N_CH-1:0]       ocupado,
  output logic [N_CH-1:0]       pendente,
  output logic [N_CH-1:0]       fim,
  output logic [N_CH-1:0]       timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(TIMEOUT_TICKS);

  logic [PW-1:0]              presc_q, presc_d;
  logic                       tick_s;
  logic [N_CH-1:0][1:0]       st_q, st_d;
  logic [N_CH-1:0][CNT_W-1:0] dur_q, dur_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_inc_s;
  logic [N_CH-1:0]            modo_q, modo_d;
  logic [N_CH-1:0]            saida_q, saida_d;
  logic [N_CH-1:0]            ocupado_q, ocupado_d;
  logic [N_CH-1:0]            pendente_q, pendente_d;
  logic [N_CH-1:0]            fim_q, fim_d;
  logic [N_CH-1:0]            timeout_q, timeout_d;
  logic                       busy_s;
  logic                       granted_s;

  // Shared free-running prescaler producing the one-cycle time tick.
  always_comb begin
    tick_s = (presc_q == PRESC_MAX);
    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Per-channel next state: run completion, interlock grant, new requests, then abort override.
  always_comb begin
    st_d      = st_q;
    dur_d     = dur_q;
    cnt_d     = cnt_q;
    modo_d    = modo_q;
    timeout_d = '0;
    busy_s    = 1'b0;
    granted_s = 1'b0;

    for (int i = 0; i < N_CH; i++) begin
      cnt_inc_s[i] = cnt_q[i] + CNT_W'(1);
      case (st_q[i])
        S_RUN: begin
          if (tick_s) begin
            cnt_d[i] = cnt_inc_s[i];
          end else begin
            cnt_d[i] = cnt_q[i];
          end
          if (!modo_q[i]) begin
            if (tick_s && (cnt_inc_s[i] == dur_q[i])) begin
              st_d[i] = S_DONE;
            end else begin
              st_d[i] = S_RUN;
            end
          end else if (fim_ext[i]) begin
            // fim_ext beats a coinciding timeout
            st_d[i] = S_DONE;
          end else if (tick_s && (cnt_inc_s[i] == TMO_CNT)) begin
            st_d[i]      = S_IDLE;
            timeout_d[i] = 1'b1;
          end else begin
            st_d[i] = S_RUN;
          end
        end
        S_DONE:  st_d[i] = S_IDLE;
        default: st_d[i] = st_q[i];
      endcase
    end

    // A masked channel leaving RUN this cycle frees the slot for the same edge.
    for (int i = 0; i < N_CH; i++) begin
      if (EXCL_MASK[i] && (st_q[i] == S_RUN) && (st_d[i] == S_RUN) && !aborta[i]) begin
        busy_s = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end

    for (int i = 0; i < N_CH; i++) begin
      if (!busy_s && !granted_s && EXCL_MASK[i] && (st_q[i] == S_PEND) && !aborta[i]) begin
        st_d[i]   = S_RUN;
        granted_s = 1'b1;
      end else begin
        granted_s = granted_s;
      end
    end

    for (int i = 0; i < N_CH; i++) begin
      if ((st_q[i] == S_IDLE) && liga[i] && !aborta[i]) begin
        dur_d[i]  = duracao[i*CNT_W +: CNT_W];
        modo_d[i] = modo_ext[i];
        cnt_d[i]  = '0;
        if (!modo_ext[i] && (duracao[i*CNT_W +: CNT_W] == '0)) begin
          st_d[i] = S_DONE;
        end else if (!EXCL_MASK[i]) begin
          st_d[i] = S_RUN;
        end else if (!busy_s && !granted_s) begin
          st_d[i]   = S_RUN;
          granted_s = 1'b1;
        end else begin
          st_d[i] = S_PEND;
        end
      end else begin
        dur_d[i] = dur_d[i];
      end
    end

    for (int i = 0; i < N_CH; i++) begin
      if (aborta[i]) begin
        st_d[i]      = S_IDLE;
        timeout_d[i] = 1'b0;
      end else begin
        st_d[i] = st_d[i];
      end
    end
  end

  // Output flags decoded from the next state so they are registered alongside it.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      saida_d[i]    = (st_d[i] == S_RUN);
      ocupado_d[i]  = (st_d[i] != S_IDLE);
      pendente_d[i] = (st_d[i] == S_PEND);
      fim_d[i]      = (st_d[i] == S_DONE);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_q    <= '0;
      st_q       <= '0;
      dur_q      <= '0;
      cnt_q      <= '0;
      modo_q     <= '0;
      saida_q    <= '0;
      ocupado_q  <= '0;
      pendente_q <= '0;
      fim_q      <= '0;
      timeout_q  <= '0;
    end else begin
      presc_q    <= presc_d;
      st_q       <= st_d;
      dur_q      <= dur_d;
      cnt_q      <= cnt_d;
      modo_q     <= modo_d;
      saida_q    <= saida_d;
      ocupado_q  <= ocupado_d;
      pendente_q <= pendente_d;
      fim_q      <= fim_d;
      timeout_q  <= timeout_d;
    end
  end

  assign saida    = saida_q;
  assign ocupado  = ocupado_q;
  assign pendente = pendente_q;
  assign fim      = fim_q;
  assign timeout  = timeout_q;

endmodule
